// File: rtl/pb_boot_pkg.sv
// Shared types and constants for the tile boot sequencer.
package pb_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClkOn,
    StRstRel,
    StWake,
    StWaitEoc,
    StDone
  } boot_state_e;

  typedef logic [31:0] exit_t;

  localparam exit_t TimeoutExitCode = 32'hFFFF_FFFF;

endpackage

// File: rtl/pb_boot_delay_cnt.sv
// Loadable down-counter with zero flag; used for settle delays and the EOC watchdog.
module pb_boot_delay_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pb_tile_boot_ctrl.sv
// Tile boot sequencer: clock on, reset release, per-tile wake, EOC/exit-code collection.
// Optional EOC watchdog enabled by defining PB_BOOT_TIMEOUT_EN.
module pb_tile_boot_ctrl
  import pb_boot_pkg::*;
#(
  parameter int unsigned NumTiles        = 16,
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned ClkSettleCycles = 8,
  parameter int unsigned RstSettleCycles = 4,
  parameter int unsigned TimeoutCycles   = 2 ** 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NumTiles-1:0]    tile_mask_i,
  input  logic [AddrWidth-1:0]   entry_i,
  output logic [NumTiles-1:0]    tile_clk_en_o,
  output logic [NumTiles-1:0]    tile_rst_o,
  output logic [NumTiles-1:0]    tile_wake_o,
  output logic [AddrWidth-1:0]   tile_entry_o,
  input  logic [NumTiles-1:0]    tile_eoc_i,
  input  logic [NumTiles*32-1:0] tile_exit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output exit_t                  exit_code_o,
  output logic [NumTiles-1:0]    fail_mask_o,
  output logic                   timeout_o
);

  boot_state_e         state_q;
  logic [NumTiles-1:0] mask_q, pend_q, eoc_seen_q;
  logic [NumTiles-1:0] mask_lo, pend_lo, new_eoc, eoc_seen_d, fail_d;
  exit_t               exit_d;
  logic                cap_en, found;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [31:0]         cnt_val;

  pb_boot_delay_cnt #(
    .Width(32)
  ) u_delay_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // Lowest set bit selects the next tile to wake.
  assign mask_lo = mask_q & (~mask_q + NumTiles'(1));
  assign pend_lo = pend_q & (~pend_q + NumTiles'(1));

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        cnt_load = start_i;
        cnt_val  = 32'(ClkSettleCycles - 1);
      end
      StClkOn: begin
        cnt_load = cnt_zero;
        cnt_val  = 32'(RstSettleCycles - 1);
        cnt_dec  = ~cnt_zero;
      end
      StRstRel: cnt_dec = 1'b1;
      StWake: begin
        cnt_load = (pend_q == '0);
        cnt_val  = 32'(TimeoutCycles - 1);
      end
`ifdef PB_BOOT_TIMEOUT_EN
      StWaitEoc: cnt_dec = 1'b1;
`endif
      default: ;
    endcase
  end

  // The first EOC of each masked tile captures its code; the reported exit code
  // tracks the lowest-index failing tile, so an existing lower failure wins.
  always_comb begin
    cap_en     = (state_q == StWake) || (state_q == StWaitEoc);
    new_eoc    = cap_en ? (tile_eoc_i & mask_q & ~eoc_seen_q) : '0;
    eoc_seen_d = eoc_seen_q | new_eoc;
    fail_d     = fail_mask_o;
    exit_d     = exit_code_o;
    found      = 1'b0;
    for (int unsigned i = 0; i < NumTiles; i++) begin
      if (new_eoc[i] && (tile_exit_i[i*32 +: 32] != '0)) begin
        fail_d[i] = 1'b1;
      end
      if (!found) begin
        if (fail_mask_o[i]) begin
          found = 1'b1;
        end else if (new_eoc[i] && (tile_exit_i[i*32 +: 32] != '0)) begin
          exit_d = tile_exit_i[i*32 +: 32];
          found  = 1'b1;
        end
      end
    end
  end

`ifdef PB_BOOT_TIMEOUT_EN
  logic timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      pend_q        <= '0;
      eoc_seen_q    <= '0;
      tile_clk_en_o <= '0;
      tile_rst_o    <= '1;
      tile_wake_o   <= '0;
      tile_entry_o  <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      exit_code_o   <= '0;
      fail_mask_o   <= '0;
`ifdef PB_BOOT_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      tile_wake_o <= '0;
      if (cap_en) begin
        eoc_seen_q  <= eoc_seen_d;
        fail_mask_o <= fail_d;
        exit_code_o <= exit_d;
      end
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            mask_q       <= tile_mask_i;
            tile_entry_o <= entry_i;
            eoc_seen_q   <= '0;
            done_o       <= 1'b0;
            exit_code_o  <= '0;
            fail_mask_o  <= '0;
`ifdef PB_BOOT_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
            if (tile_mask_i == '0) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end else begin
              state_q       <= StClkOn;
              busy_o        <= 1'b1;
              tile_clk_en_o <= tile_mask_i;
              tile_rst_o    <= '1;
            end
          end
        end
        StClkOn: begin
          if (cnt_zero) begin
            state_q    <= StRstRel;
            tile_rst_o <= ~mask_q;
          end
        end
        StRstRel: begin
          if (cnt_zero) begin
            state_q     <= StWake;
            tile_wake_o <= mask_lo;
            pend_q      <= mask_q & ~mask_lo;
          end
        end
        StWake: begin
          tile_wake_o <= pend_lo;
          pend_q      <= pend_q & ~pend_lo;
          if (pend_q == '0) state_q <= StWaitEoc;
        end
        StWaitEoc: begin
          if (eoc_seen_d == mask_q) begin
            state_q <= StDone;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
`ifdef PB_BOOT_TIMEOUT_EN
          end else if (cnt_zero) begin
            state_q     <= StDone;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            timeout_q   <= 1'b1;
            exit_code_o <= TimeoutExitCode;
            fail_mask_o <= fail_d | (mask_q & ~eoc_seen_d);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_tile_boot_ctrl.sv
// Scoreboard bench for pb_tile_boot_ctrl; timeout scenario runs when PB_BOOT_TIMEOUT_EN is defined.
module tb_pb_tile_boot_ctrl;
  import pb_boot_pkg::*;

  localparam int unsigned NT = 16;
  localparam int unsigned AW = 48;
  localparam int unsigned CS = 8;
  localparam int unsigned RS = 4;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [NT-1:0]   tile_mask = '0, tile_eoc = '0;
  logic [AW-1:0]   entry = '0;
  logic [NT*32-1:0] tile_exit = '0;
  logic [NT-1:0]   tile_clk_en_o, tile_rst_o, tile_wake_o, fail_mask_o;
  logic [AW-1:0]   tile_entry_o;
  logic            busy_o, done_o, timeout_o;
  exit_t           exit_code_o;

  pb_tile_boot_ctrl #(
    .NumTiles       (NT),
    .AddrWidth      (AW),
    .ClkSettleCycles(CS),
    .RstSettleCycles(RS),
    .TimeoutCycles  (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .tile_mask_i  (tile_mask),
    .entry_i      (entry),
    .tile_clk_en_o(tile_clk_en_o),
    .tile_rst_o   (tile_rst_o),
    .tile_wake_o  (tile_wake_o),
    .tile_entry_o (tile_entry_o),
    .tile_eoc_i   (tile_eoc),
    .tile_exit_i  (tile_exit),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .exit_code_o  (exit_code_o),
    .fail_mask_o  (fail_mask_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   exit_code;
    logic [NT-1:0] fail;
    logic          timeout;
  } result_t;

  result_t       exp_q[$];
  int            n_cmp = 0, n_bad = 0;
  logic [NT-1:0] m_mask, m_seen;
  logic [31:0]   m_code[NT];
  logic [AW-1:0] m_entry;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic result_t model_result();
    result_t r;
    logic    found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (m_seen[i] && m_code[i] != 0) begin
        r.fail[i] = 1'b1;
        if (!found) begin
          r.exit_code = m_code[i];
          found       = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic check_result();
    result_t r;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'd0, 64'd1);
      return;
    end
    r = exp_q.pop_front();
    check_val("exit_code", 64'(exit_code_o), 64'(r.exit_code));
    check_val("fail_mask", 64'(fail_mask_o), 64'(r.fail));
    check_val("timeout", 64'(timeout_o), 64'(r.timeout));
    check_val("busy_done", 64'({busy_o, done_o}), 64'(2'b01));
    check_val("entry_hold", 64'(tile_entry_o), 64'(m_entry));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("done_wait", 64'(done_o), 64'd1);
  endtask

  // Start a boot and compare every cycle against the expected sequence up to cycle 'stop'.
  task automatic run_seq(input logic [NT-1:0] mask, input logic [AW-1:0] ent, input int stop);
    int            k, last, n, cnt;
    logic [NT-1:0] exp_r, exp_w;
    start     = 1'b1;
    tile_mask = mask;
    entry     = ent;
    m_mask    = mask;
    m_entry   = ent;
    m_seen    = '0;
    k         = $countones(mask);
    last      = (stop == 0) ? int'(1 + CS + RS) + k : stop;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check_val("entry_latch", 64'(tile_entry_o), 64'(ent));
      end
      exp_r = (c <= int'(CS)) ? '1 : ~mask;
      exp_w = '0;
      n     = c - int'(1 + CS + RS);
      cnt   = 0;
      for (int i = 0; i < NT; i++) begin
        if (mask[i]) begin
          if (cnt == n) exp_w[i] = 1'b1;
          cnt++;
        end
      end
      check_val($sformatf("seq_c%0d", c),
                64'({busy_o, done_o, tile_clk_en_o, tile_rst_o, tile_wake_o}),
                64'({1'b1, 1'b0, mask, exp_r, exp_w}));
    end
  endtask

  // One cycle of EOC on the given tiles, all reporting 'code'; other lanes carry junk.
  task automatic drv_eoc(input logic [NT-1:0] eoc, input logic [31:0] code);
    logic was_done;
    was_done = (m_seen == m_mask);
    tile_eoc = eoc;
    for (int i = 0; i < NT; i++) begin
      tile_exit[i*32 +: 32] = eoc[i] ? code : (32'hBAD0_0000 | 32'(i));
      if (eoc[i] && m_mask[i] && !m_seen[i]) begin
        m_seen[i] = 1'b1;
        m_code[i] = code;
      end
    end
    @(negedge clk);
    tile_eoc = '0;
    if (!was_done && m_seen == m_mask) begin
      exp_q.push_back(model_result());
      check_val("done_lat", 64'(done_o), 64'd1);
      check_result();
    end else begin
      check_val("not_done", 64'(done_o), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    result_t r;
    repeat (3) @(negedge clk);
    check_val("rst_ctl", 64'({busy_o, done_o, timeout_o, tile_clk_en_o, tile_wake_o}), 64'd0);
    check_val("rst_tile_rst", 64'(tile_rst_o), 64'(16'hFFFF));
    check_val("rst_res", 64'({exit_code_o, fail_mask_o}), 64'd0);
    check_val("rst_entry", 64'(tile_entry_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Empty mask: done next cycle, no tile activity.
    start     = 1'b1;
    tile_mask = '0;
    entry     = 48'h55;
    m_mask    = '0;
    m_seen    = '0;
    m_entry   = 48'h55;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(model_result());
    check_val("m0_tiles", 64'({tile_clk_en_o, tile_wake_o, tile_rst_o}), 64'({32'h0, 16'hFFFF}));
    check_result();

    // Two tiles, both succeed in the same cycle.
    run_seq(16'h0005, 48'h0000_8000_0000, 0);
    drv_eoc(16'h0005, 32'h0);

    // Staggered failures, repeat EOC and a start during WAIT_EOC are ignored.
    run_seq(16'h0005, 48'h0000_8000_0000, 0);
    drv_eoc(16'h0004, 32'h3);
    start     = 1'b1;
    tile_mask = 16'hFFFF;
    entry     = 48'h1234;
    @(negedge clk);
    start = 1'b0;
    check_val("ign_start", 64'({busy_o, done_o, tile_clk_en_o}), 64'({2'b10, 16'h0005}));
    check_val("ign_entry", 64'(tile_entry_o), 64'(48'h0000_8000_0000));
    drv_eoc(16'h0004, 32'h7);
    drv_eoc(16'h0001, 32'h5);

    // Lowest failing index wins regardless of arrival order; unmasked EOC ignored.
    run_seq(16'h00F0, 48'hABCD_0000_1000, 0);
    drv_eoc(16'h0081, 32'h2);
    drv_eoc(16'h0020, 32'h4);
    drv_eoc(16'h0040, 32'h1);
    drv_eoc(16'h0010, 32'h0);

    // Reset during RST_REL aborts; restart completes.
    run_seq(16'h0012, 48'h0000_0000_4000, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_ctl", 64'({busy_o, done_o, timeout_o, tile_clk_en_o, tile_wake_o}), 64'd0);
    check_val("abort_rst", 64'(tile_rst_o), 64'(16'hFFFF));
    check_val("abort_res", 64'({exit_code_o, fail_mask_o}), 64'd0);
    check_val("abort_entry", 64'(tile_entry_o), 64'd0);
    run_seq(16'h0012, 48'h0000_0000_4000, 0);
    drv_eoc(16'h0002, 32'h0);
    drv_eoc(16'h0010, 32'h9);

`ifdef PB_BOOT_TIMEOUT_EN
    // Tile 2 never reports: watchdog ends the run.
    run_seq(16'h0005, 48'h0000_8000_0000, 0);
    drv_eoc(16'h0001, 32'h0);
    r           = model_result();
    r.timeout   = 1'b1;
    r.exit_code = 32'hFFFF_FFFF;
    r.fail      = r.fail | (m_mask & ~m_seen);
    exp_q.push_back(r);
    wait_done(int'(TO) + 20);
    check_result();
`else
    r = '0;
    check_val("timeout_tied", 64'({timeout_o, r.timeout}), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
